// File: rtl/rob_commit_sequencer_if.sv
// Interface between the reorder buffer head, the store buffer and the commit sequencer.
// The master side (ROB and store buffer) presents the oldest Q_WIDTH entries.
// The slave side (the sequencer) returns the dequeue count, the store commit
// strobe and the flush/redirect outputs.
interface rob_commit_sequencer_if #(
  parameter int Q_WIDTH   = 4,
  parameter int ADDR_BITS = 64
);
  localparam int DEQ_W = $clog2(Q_WIDTH + 1);

  logic [Q_WIDTH-1:0]           head_valid_in;
  logic [Q_WIDTH*3-1:0]         head_status_in;
  logic [Q_WIDTH-1:0]           head_is_store_in;
  logic [Q_WIDTH*ADDR_BITS-1:0] head_pc_in;
  logic [Q_WIDTH*ADDR_BITS-1:0] head_target_in;
  logic                         st_ready_in;
  logic [DEQ_W-1:0]             deq_out;
  logic [Q_WIDTH-1:0]           st_commit_out;
  logic                         flush_out;
  logic                         valid_pc_out;
  logic [ADDR_BITS-1:0]         pc_out;
  logic [ADDR_BITS-1:0]         epc_out;
  logic [2:0]                   cause_out;

  modport master (
    output head_valid_in, head_status_in, head_is_store_in, head_pc_in,
           head_target_in, st_ready_in,
    input  deq_out, st_commit_out, flush_out, valid_pc_out, pc_out,
           epc_out, cause_out
  );

  modport slave (
    input  head_valid_in, head_status_in, head_is_store_in, head_pc_in,
           head_target_in, st_ready_in,
    output deq_out, st_commit_out, flush_out, valid_pc_out, pc_out,
           epc_out, cause_out
  );
endinterface

// File: rtl/rob_commit_sequencer.sv
// ROB retirement controller: in-order commit of up to Q_WIDTH head entries per
// cycle, at most one store per cycle, and a flush/redirect sequence on
// exception, interrupt, trap or branch mispredict.
// Optional macro ROB_COMMIT_PERF_EN adds commit_cnt_out / flush_cnt_out counters.
module rob_commit_sequencer #(
  parameter int                   Q_WIDTH      = 4,
  parameter int                   ADDR_BITS    = 64,
  parameter int                   FLUSH_CYCLES = 2,
  parameter logic [ADDR_BITS-1:0] EXC_VECTOR   = 64'h0000_0000_0000_0100
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  rob_commit_sequencer_if.slave  bus
`ifdef ROB_COMMIT_PERF_EN
  ,
  output logic [31:0]            commit_cnt_out,
  output logic [31:0]            flush_cnt_out
`endif
);

  localparam int DEQ_W = $clog2(Q_WIDTH + 1);

  localparam logic [2:0] ST_DONE = 3'd1;
  localparam logic [2:0] ST_EXC  = 3'd2;
  localparam logic [2:0] ST_INT  = 3'd3;
  localparam logic [2:0] ST_TRAP = 3'd4;
  localparam logic [2:0] ST_MISP = 3'd5;

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_REDIRECT
  } state_t;

  state_t               state;
  logic [3:0]           flush_cnt;
  logic                 flush_q;
  logic                 valid_pc_q;
  logic [ADDR_BITS-1:0] pc_q;
  logic [ADDR_BITS-1:0] epc_q;
  logic [ADDR_BITS-1:0] redir_q;
  logic [2:0]           cause_q;

  logic [DEQ_W-1:0]     deq_c;
  logic [Q_WIDTH-1:0]   st_c;
  logic                 ev_c;
  logic                 ev_misp_c;
  logic [2:0]           ev_cause_c;
  logic [ADDR_BITS-1:0] ev_pc_c;
  logic [ADDR_BITS-1:0] ev_tgt_c;

  logic                 run;

  assign run = (state == S_RUN);

  // Commit scan from the oldest slot upward; also identifies the oldest event.
  // A single stop flag ends the scan at the first slot that cannot retire, so
  // only that slot may raise an exception-class event, and a retiring
  // mispredict ends the scan right after itself.
  always_comb begin
    logic       stop;
    logic       store_seen;
    logic [2:0] st_i;
    deq_c      = '0;
    st_c       = '0;
    ev_c       = 1'b0;
    ev_misp_c  = 1'b0;
    ev_cause_c = '0;
    ev_pc_c    = '0;
    ev_tgt_c   = '0;
    stop       = 1'b0;
    store_seen = 1'b0;
    st_i       = '0;
    for (int unsigned i = 0; i < Q_WIDTH; i++) begin
      st_i = bus.head_status_in[i*3 +: 3];
      if (!stop) begin
        if (!bus.head_valid_in[i]) begin
          stop = 1'b1;
        end else if (st_i == ST_DONE || st_i == ST_MISP) begin
          if (bus.head_is_store_in[i] && (store_seen || !bus.st_ready_in)) begin
            stop = 1'b1;
          end else begin
            deq_c = deq_c + 1'b1;
            if (bus.head_is_store_in[i]) begin
              st_c[i]    = 1'b1;
              store_seen = 1'b1;
            end
            if (st_i == ST_MISP) begin
              ev_c       = 1'b1;
              ev_misp_c  = 1'b1;
              ev_cause_c = st_i;
              ev_pc_c    = bus.head_pc_in[i*ADDR_BITS +: ADDR_BITS];
              ev_tgt_c   = bus.head_target_in[i*ADDR_BITS +: ADDR_BITS];
              stop       = 1'b1;
            end
          end
        end else if (st_i == ST_EXC || st_i == ST_INT || st_i == ST_TRAP) begin
          ev_c       = 1'b1;
          ev_cause_c = st_i;
          ev_pc_c    = bus.head_pc_in[i*ADDR_BITS +: ADDR_BITS];
          stop       = 1'b1;
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

  assign bus.deq_out       = run ? deq_c : '0;
  assign bus.st_commit_out = run ? st_c  : '0;
  assign bus.flush_out     = flush_q;
  assign bus.valid_pc_out  = valid_pc_q;
  assign bus.pc_out        = pc_q;
  assign bus.epc_out       = epc_q;
  assign bus.cause_out     = cause_q;

  // Flush/redirect FSM with registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= S_RUN;
      flush_cnt  <= '0;
      flush_q    <= 1'b0;
      valid_pc_q <= 1'b0;
      pc_q       <= '0;
      epc_q      <= '0;
      redir_q    <= '0;
      cause_q    <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (ev_c) begin
            state     <= S_FLUSH;
            flush_q   <= 1'b1;
            flush_cnt <= 4'd1;
            epc_q     <= ev_pc_c;
            cause_q   <= ev_cause_c;
            redir_q   <= ev_misp_c ? ev_tgt_c : EXC_VECTOR;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == 4'(FLUSH_CYCLES)) begin
            state      <= S_REDIRECT;
            flush_q    <= 1'b0;
            valid_pc_q <= 1'b1;
            pc_q       <= redir_q;
          end else begin
            flush_cnt <= flush_cnt + 4'd1;
          end
        end
        S_REDIRECT: begin
          state      <= S_RUN;
          valid_pc_q <= 1'b0;
          flush_cnt  <= '0;
        end
        default: begin
          state      <= S_RUN;
          flush_q    <= 1'b0;
          valid_pc_q <= 1'b0;
          flush_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef ROB_COMMIT_PERF_EN
  // Performance counters: retired entries and flush events, wrapping at 2^32.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      commit_cnt_out <= '0;
      flush_cnt_out  <= '0;
    end else begin
      commit_cnt_out <= commit_cnt_out + 32'(bus.deq_out);
      if (run && ev_c) begin
        flush_cnt_out <= flush_cnt_out + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit_sequencer.sv
// Self-checking bench for rob_commit_sequencer: directed scenarios followed by
// randomized head contents, compared against a cycle-timeline reference model.
module tb_rob_commit_sequencer;
  localparam int Q  = 4;
  localparam int AB = 64;
  localparam int F  = 2;
  localparam logic [63:0] VEC = 64'h100;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  rob_commit_sequencer_if #(.Q_WIDTH(Q), .ADDR_BITS(AB)) bus ();

`ifdef ROB_COMMIT_PERF_EN
  logic [31:0] commit_cnt_out;
  logic [31:0] flush_cnt_out;
`endif

  rob_commit_sequencer #(
    .Q_WIDTH(Q), .ADDR_BITS(AB), .FLUSH_CYCLES(F), .EXC_VECTOR(VEC)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
`ifdef ROB_COMMIT_PERF_EN
    ,
    .commit_cnt_out(commit_cnt_out),
    .flush_cnt_out(flush_cnt_out)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference timeline: cycle index, cycle of the last event, and held values.
  int          cyc    = 0;
  int          ev_cyc = -100;
  logic [63:0] m_pc, m_epc, m_redir;
  logic [2:0]  m_cause;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.head_valid_in    = '0;
    bus.head_status_in   = '0;
    bus.head_is_store_in = '0;
    bus.head_pc_in       = '0;
    bus.head_target_in   = '0;
    bus.st_ready_in      = 1'b1;
  endtask

  task automatic set_slot(input int i, input logic [2:0] s, input logic st,
                          input logic [63:0] pc, input logic [63:0] tgt);
    bus.head_valid_in[i]            = 1'b1;
    bus.head_status_in[i*3 +: 3]    = s;
    bus.head_is_store_in[i]         = st;
    bus.head_pc_in[i*AB +: AB]      = pc;
    bus.head_target_in[i*AB +: AB]  = tgt;
  endtask

  task automatic model_reset();
    ev_cyc  = -100;
    m_pc    = '0;
    m_epc   = '0;
    m_redir = '0;
    m_cause = '0;
  endtask

  // Retire the longest eligible prefix of the head, then look for the oldest event.
  function automatic void ref_scan(output int deq, output logic [3:0] sc, output bit ev,
                                   output logic [63:0] epc, output logic [2:0] cs,
                                   output logic [63:0] rd);
    bit         store_used;
    int         n;
    logic [2:0] s;
    deq = 0; sc = '0; ev = 0; epc = '0; cs = '0; rd = '0;
    store_used = 0;
    n = 0;
    while (n < Q) begin
      s = bus.head_status_in[n*3 +: 3];
      if (!bus.head_valid_in[n] || !(s == 3'd1 || s == 3'd5)) break;
      if (bus.head_is_store_in[n]) begin
        if (store_used || !bus.st_ready_in) break;
        store_used = 1;
        sc[n] = 1'b1;
      end
      n++;
      if (s == 3'd5) begin
        ev  = 1;
        cs  = 3'd5;
        epc = bus.head_pc_in[(n-1)*AB +: AB];
        rd  = bus.head_target_in[(n-1)*AB +: AB];
        break;
      end
    end
    deq = n;
    if (!ev && n < Q && bus.head_valid_in[n]) begin
      s = bus.head_status_in[n*3 +: 3];
      if (s >= 3'd2 && s <= 3'd4) begin
        ev  = 1;
        cs  = s;
        epc = bus.head_pc_in[n*AB +: AB];
        rd  = VEC;
      end
    end
  endfunction

  // One clock cycle: check all outputs mid-cycle, then advance the model.
  task automatic tick();
    int          d, age;
    logic [3:0]  sc;
    bit          ev;
    logic [63:0] epc, rd;
    logic [2:0]  cs;
    @(negedge clk_in);
    age = cyc - ev_cyc;
    chk("flush_out", 64'(bus.flush_out), 64'(age >= 1 && age <= F));
    chk("valid_pc_out", 64'(bus.valid_pc_out), 64'(age == F + 1));
    chk("pc_out", bus.pc_out, m_pc);
    chk("epc_out", bus.epc_out, m_epc);
    chk("cause_out", 64'(bus.cause_out), 64'(m_cause));
    ref_scan(d, sc, ev, epc, cs, rd);
    if (age >= 1 && age <= F + 1) begin
      d = 0; sc = '0; ev = 0;
    end
    chk("deq_out", 64'(bus.deq_out), 64'(d));
    chk("st_commit_out", 64'(bus.st_commit_out), 64'(sc));
    @(posedge clk_in);
    #1;
    cyc++;
    if (ev) begin
      ev_cyc  = cyc - 1;
      m_epc   = epc;
      m_cause = cs;
      m_redir = rd;
    end
    if (cyc - ev_cyc == F + 1) m_pc = m_redir;
  endtask

  initial begin
    logic [2:0] s;
    clear_inputs();
    model_reset();
    rst_in = 1'b1;
    #1;
    chk("reset_deq", 64'(bus.deq_out), 64'd0);
    chk("reset_flush", 64'(bus.flush_out), 64'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    tick();

    // Full-width commit, no stores
    for (int i = 0; i < Q; i++) set_slot(i, 3'd1, 1'b0, 64'h1000 + 64'(4*i), 64'h0);
    #1;
    chk("commit_run_deq", 64'(bus.deq_out), 64'd4);
    chk("commit_run_st", 64'(bus.st_commit_out), 64'd0);
    tick();
    chk("commit_run_flush", 64'(bus.flush_out), 64'd0);

    // Store limit with and without store buffer ready
    bus.head_is_store_in = 4'b0110;
    bus.st_ready_in = 1'b1;
    #1;
    chk("store_lim_deq", 64'(bus.deq_out), 64'd2);
    chk("store_lim_st", 64'(bus.st_commit_out), 64'b0010);
    tick();
    bus.st_ready_in = 1'b0;
    #1;
    chk("store_nrdy_deq", 64'(bus.deq_out), 64'd1);
    chk("store_nrdy_st", 64'(bus.st_commit_out), 64'd0);
    tick();

    // Exception at slot 1
    clear_inputs();
    set_slot(0, 3'd1, 1'b0, 64'h1ffc, 64'h0);
    set_slot(1, 3'd2, 1'b0, 64'h2000, 64'h0);
    set_slot(2, 3'd1, 1'b0, 64'h2004, 64'h0);
    #1;
    chk("exc_deq", 64'(bus.deq_out), 64'd1);
    tick();
    clear_inputs();
    chk("exc_flush_t1", 64'(bus.flush_out), 64'd1);
    chk("exc_epc", bus.epc_out, 64'h2000);
    chk("exc_cause", 64'(bus.cause_out), 64'd2);
    tick();
    chk("exc_flush_t2", 64'(bus.flush_out), 64'd1);
    tick();
    chk("exc_vpc_t3", 64'(bus.valid_pc_out), 64'd1);
    chk("exc_pc_t3", bus.pc_out, 64'h100);
    chk("exc_flush_t3", 64'(bus.flush_out), 64'd0);
    tick();
    chk("exc_vpc_t4", 64'(bus.valid_pc_out), 64'd0);

    // Mispredict at slot 0: branch retires, younger slot does not
    set_slot(0, 3'd5, 1'b0, 64'h3000, 64'h4040);
    set_slot(1, 3'd1, 1'b0, 64'h3004, 64'h0);
    #1;
    chk("misp_deq", 64'(bus.deq_out), 64'd1);
    tick();
    clear_inputs();
    tick();
    tick();
    chk("misp_vpc", 64'(bus.valid_pc_out), 64'd1);
    chk("misp_pc", bus.pc_out, 64'h4040);
    chk("misp_cause", 64'(bus.cause_out), 64'd5);
    chk("misp_epc", bus.epc_out, 64'h3000);
    tick();

    // Trap behind a pending entry is not taken until the pending entry completes
    set_slot(0, 3'd0, 1'b0, 64'h5000, 64'h0);
    set_slot(1, 3'd4, 1'b0, 64'h5004, 64'h0);
    #1;
    chk("block_deq", 64'(bus.deq_out), 64'd0);
    tick();
    chk("block_noflush", 64'(bus.flush_out), 64'd0);
    set_slot(0, 3'd1, 1'b0, 64'h5000, 64'h0);
    #1;
    chk("block_go_deq", 64'(bus.deq_out), 64'd1);
    tick();
    clear_inputs();
    chk("block_flush", 64'(bus.flush_out), 64'd1);
    chk("block_cause", 64'(bus.cause_out), 64'd4);
    for (int i = 0; i < 3; i++) tick();

    // Asynchronous reset during flush abandons the redirect
    set_slot(0, 3'd3, 1'b0, 64'h6000, 64'h0);
    tick();
    clear_inputs();
    #1;
    chk("rst_pre_flush", 64'(bus.flush_out), 64'd1);
    rst_in = 1'b1;
    #1;
    chk("rst_flush", 64'(bus.flush_out), 64'd0);
    chk("rst_vpc", 64'(bus.valid_pc_out), 64'd0);
    chk("rst_pc", bus.pc_out, 64'd0);
    chk("rst_epc", bus.epc_out, 64'd0);
    chk("rst_cause", 64'(bus.cause_out), 64'd0);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 5; i++) tick();
    set_slot(0, 3'd1, 1'b0, 64'h7000, 64'h0);
    #1;
    chk("rst_run_deq", 64'(bus.deq_out), 64'd1);
    tick();

    // Randomized head contents
    for (int n = 0; n < 600; n++) begin
      clear_inputs();
      bus.st_ready_in = 1'($urandom_range(0, 3) != 0);
      for (int i = 0; i < Q; i++) begin
        if ($urandom_range(0, 7) != 0) begin
          s = ($urandom_range(0, 15) < 9) ? 3'd1 : 3'($urandom_range(0, 7));
          set_slot(i, s, (s != 3'd5) && ($urandom_range(0, 2) == 0),
                   {$urandom, $urandom}, {$urandom, $urandom});
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
